// File: rtl/mac_pe.sv
// Systolic-array MAC processing element: forwards operands east/south, multiplies in a
// registered product stage, accumulates at ACC_W precision and drains results down a column.
//
// state  | meaning
// EMPTY  | no tile in progress; next product seeds the accumulator
// ACTIVE | tile in progress; products add into the accumulator
module mac_pe #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int OUT_W  = 32,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              signed_en,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_a_valid,
  input  logic              in_first,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_b_valid,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_valid,
  output logic              out_first,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  input  logic              res_load,
  input  logic              shift,
  input  logic [OUT_W-1:0]  psum_in,
  input  logic              psum_in_valid,
  output logic [OUT_W-1:0]  psum_out,
  output logic              psum_out_valid,
  output logic              sat_flag,
  output logic              seq_err
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } acc_state_t;

  acc_state_t       state;
  logic             fire;
  logic [PW-1:0]    a_ext, b_ext, prod_c;
  logic [PW-1:0]    prod;
  logic             prod_v, prod_first, prod_sgn;
  logic [ACC_W-1:0] prod_ext, acc, acc_next;
  logic             acc_sgn, res_sgn, seq_hit;
  logic [OUT_W-1:0] res_val;
  logic             res_clamp;

  assign fire = in_a_valid & in_b_valid;

  // operand forwarding to east and south neighbours
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a       <= '0;
      out_a_valid <= 1'b0;
      out_first   <= 1'b0;
      out_b       <= '0;
      out_b_valid <= 1'b0;
    end else begin
      out_a       <= in_a;
      out_a_valid <= in_a_valid;
      out_first   <= in_first;
      out_b       <= in_b;
      out_b_valid <= in_b_valid;
    end
  end

  // one multiplier serves both modes: operands are sign- or zero-extended to PW first
  always_comb begin
    a_ext  = {{DATA_W{signed_en & in_a[DATA_W-1]}}, in_a};
    b_ext  = {{DATA_W{signed_en & in_b[DATA_W-1]}}, in_b};
    prod_c = a_ext * b_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_v     <= 1'b0;
      prod_first <= 1'b0;
      prod_sgn   <= 1'b0;
    end else begin
      prod       <= prod_c;
      prod_v     <= fire;
      prod_first <= in_first & fire;
      prod_sgn   <= signed_en;
    end
  end

  always_comb begin
    prod_ext          = {ACC_W{prod_sgn & prod[PW-1]}};
    prod_ext[PW-1:0]  = prod;
  end

  // acc_next is also the capture source, so a same-cycle product is never lost
  always_comb begin
    acc_next = acc;
    res_sgn  = acc_sgn;
    seq_hit  = 1'b0;
    if (prod_v) begin
      res_sgn = prod_sgn;
      if (prod_first || state == EMPTY) acc_next = prod_ext;
      else                              acc_next = acc + prod_ext;
      seq_hit = !prod_first && (state == EMPTY || res_load);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      acc     <= '0;
      acc_sgn <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      if (seq_hit) seq_err <= 1'b1;
      if (prod_v)  acc_sgn <= prod_sgn;
      case (state)
        EMPTY, ACTIVE: begin
          if (res_load) begin
            if (prod_v) begin
              acc   <= prod_ext;
              state <= ACTIVE;
            end else begin
              acc   <= '0;
              state <= EMPTY;
            end
          end else if (prod_v) begin
            acc   <= acc_next;
            state <= ACTIVE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  generate
    if (OUT_W < ACC_W) begin : g_narrow
      logic s_neg, s_ovf, u_ovf;
      always_comb begin
        s_neg     = acc_next[ACC_W-1];
        s_ovf     = acc_next[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){s_neg}};
        u_ovf     = |acc_next[ACC_W-1:OUT_W];
        res_val   = acc_next[OUT_W-1:0];
        res_clamp = 1'b0;
        if (SAT != 0) begin
          if (res_sgn && s_ovf) begin
            res_clamp = 1'b1;
            res_val   = s_neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
          end else if (!res_sgn && u_ovf) begin
            res_clamp = 1'b1;
            res_val   = '1;
          end
        end
      end
    end else begin : g_full
      assign res_val   = acc_next[OUT_W-1:0];
      assign res_clamp = 1'b0;
    end
  endgenerate

  // drain register: a local capture wins over shifting the chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_out       <= '0;
      psum_out_valid <= 1'b0;
      sat_flag       <= 1'b0;
    end else if (res_load) begin
      psum_out       <= res_val;
      psum_out_valid <= 1'b1;
      sat_flag       <= res_clamp;
    end else if (shift) begin
      psum_out       <= psum_in;
      psum_out_valid <= psum_in_valid;
      sat_flag       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe: a 3-PE drain column (SAT=1) plus a SAT=0 twin of the bottom PE,
// with queued expected drain outputs checked by independent monitors.
module tb_mac_pe;

  logic        clk, rst_n, signed_en, res_load, shift;
  logic [31:0] a[3], b[3];
  logic        av[3], bv[3], fst[3];
  logic [31:0] oa[3], ob[3], po[3], pi[3];
  logic        oav[3], ofst[3], obv[3], pov[3], sf[3], se[3], piv[3];

  logic [31:0] oa_ns, ob_ns, po_ns;
  logic        oav_ns, ofst_ns, obv_ns, pov_ns, sf_ns, se_ns;

  typedef struct {
    string       nm;
    logic [31:0] v;
    logic        s;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic upd = 1'b0;

  assign pi[0]  = 32'd0;
  assign piv[0] = 1'b0;
  assign pi[1]  = po[0];
  assign piv[1] = pov[0];
  assign pi[2]  = po[1];
  assign piv[2] = pov[1];

  for (genvar i = 0; i < 3; i++) begin : g_pe
    mac_pe #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .SAT(1)) u_pe (
      .clk(clk), .rst_n(rst_n), .signed_en(signed_en),
      .in_a(a[i]), .in_a_valid(av[i]), .in_first(fst[i]),
      .in_b(b[i]), .in_b_valid(bv[i]),
      .out_a(oa[i]), .out_a_valid(oav[i]), .out_first(ofst[i]),
      .out_b(ob[i]), .out_b_valid(obv[i]),
      .res_load(res_load), .shift(shift),
      .psum_in(pi[i]), .psum_in_valid(piv[i]),
      .psum_out(po[i]), .psum_out_valid(pov[i]),
      .sat_flag(sf[i]), .seq_err(se[i])
    );
  end

  mac_pe #(.DATA_W(32), .ACC_W(64), .OUT_W(32), .SAT(0)) u_ns (
    .clk(clk), .rst_n(rst_n), .signed_en(signed_en),
    .in_a(a[2]), .in_a_valid(av[2]), .in_first(fst[2]),
    .in_b(b[2]), .in_b_valid(bv[2]),
    .out_a(oa_ns), .out_a_valid(oav_ns), .out_first(ofst_ns),
    .out_b(ob_ns), .out_b_valid(obv_ns),
    .res_load(res_load), .shift(shift),
    .psum_in(32'd0), .psum_in_valid(1'b0),
    .psum_out(po_ns), .psum_out_valid(pov_ns),
    .sat_flag(sf_ns), .seq_err(se_ns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // a drain output is presented on an edge that saw res_load or shift
  always @(posedge clk) upd <= res_load | shift;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && upd) begin
      if (pov[2]) begin
        if (q1.size() == 0) chk("sat1 unexpected output", {32'd0, po[2]}, 64'd0 - 64'd1);
        else begin
          e = q1.pop_front();
          chk({"sat1 psum ", e.nm}, {32'd0, po[2]}, {32'd0, e.v});
          chk({"sat1 flag ", e.nm}, {63'd0, sf[2]}, {63'd0, e.s});
        end
      end
      if (pov_ns) begin
        if (q0.size() == 0) chk("sat0 unexpected output", {32'd0, po_ns}, 64'd0 - 64'd1);
        else begin
          e = q0.pop_front();
          chk({"sat0 psum ", e.nm}, {32'd0, po_ns}, {32'd0, e.v});
          chk({"sat0 flag ", e.nm}, {63'd0, sf_ns}, {63'd0, e.s});
        end
      end
    end
  end

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic va,
                       input logic vb, input logic f, input logic rl);
    @(negedge clk);
    a[2] = aa; b[2] = bb; av[2] = va; bv[2] = vb; fst[2] = f;
    res_load = rl; shift = 1'b0;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push(input string nm, input logic [31:0] v1, input logic s1,
                      input logic [31:0] v0, input logic s0);
    exp_t e;
    e.nm = nm; e.v = v1; e.s = s1; q1.push_back(e);
    e.v = v0; e.s = s0; q0.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; signed_en = 1'b1; res_load = 1'b0; shift = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = '0; b[i] = '0; av[i] = 1'b0; bv[i] = 1'b0; fst[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("reset psum_out_valid", {63'd0, pov[2]}, 64'd0);
    chk("reset psum_out", {32'd0, po[2]}, 64'd0);
    rst_n = 1'b1;
    idle(); idle();
    chk("post-reset seq_err", {63'd0, se[2]}, 64'd0);
    chk("post-reset psum_out_valid", {63'd0, pov[2]}, 64'd0);

    // signed dot product 3*4 - 5*6 - 7*2 = -32
    signed_en = 1'b1;
    drive(32'd3, 32'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(-32'sd5, 32'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(32'd7, -32'sd2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    push("dot", 32'hFFFF_FFE0, 1'b0, 32'hFFFF_FFE0, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("dot seq_err", {63'd0, se[2]}, 64'd0);

    // unsigned 0xFFFFFFFF^2 overflows OUT_W
    signed_en = 1'b0;
    drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    push("usat", 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("usat seq_err", {63'd0, se[2]}, 64'd0);

    // back-to-back tiles, load on the first tile's acc_next cycle
    signed_en = 1'b1;
    drive(32'd2, 32'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(32'd4, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    push("tile1", 32'd26, 1'b0, 32'd26, 1'b0);
    drive(32'd1, 32'd1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(); idle();
    push("tile2", 32'd1, 1'b0, 32'd1, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // asynchronous reset in mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async psum_out_valid", {63'd0, pov[2]}, 64'd0);
    chk("async psum_out", {32'd0, po[2]}, 64'd0);
    chk("async seq_err", {63'd0, se[2]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("release psum_out_valid", {63'd0, pov[2]}, 64'd0);
    chk("release seq_err", {63'd0, se[2]}, 64'd0);

    // fire without first from EMPTY, then a lone a-valid
    drive(32'd5, 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(32'd9, 32'd100, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("lone a out_a_valid", {63'd0, oav[2]}, 64'd1);
    chk("lone a out_a", {32'd0, oa[2]}, 64'd9);
    chk("lone a out_b_valid", {63'd0, obv[2]}, 64'd0);
    chk("no-first seq_err", {63'd0, se[2]}, 64'd1);
    push("nofirst", 32'd35, 1'b0, 32'd35, 1'b0);
    drive(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("seq_err sticky", {63'd0, se[2]}, 64'd1);

    // drain column holding 10, 20, 30 top to bottom
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'(10 * (i + 1)); b[i] = 32'd1; av[i] = 1'b1; bv[i] = 1'b1; fst[i] = 1'b1;
    end
    res_load = 1'b0; shift = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      av[i] = 1'b0; bv[i] = 1'b0; fst[i] = 1'b0;
    end
    push("drain0", 32'd30, 1'b0, 32'd30, 1'b0);
    exp_t_push_drain();
    @(negedge clk); res_load = 1'b1;
    @(negedge clk); res_load = 1'b0; shift = 1'b1;
    @(negedge clk); shift = 1'b1;
    @(negedge clk); shift = 1'b0;
    idle(); idle();

    chk("sat1 queue drained", 64'(q1.size()), 64'd0);
    chk("sat0 queue drained", 64'(q0.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // the shifted-in entries reach only the SAT=1 bottom PE
  task automatic exp_t_push_drain();
    exp_t e;
    e.s = 1'b0;
    e.nm = "drain1"; e.v = 32'd20; q1.push_back(e);
    e.nm = "drain2"; e.v = 32'd10; q1.push_back(e);
  endtask

endmodule
